// File: rtl/cpu_bus_pkg.sv
// Shared 2A03 bus definitions: DMA state encoding, fixed register addresses
// and the 16-bit address type used by the DMA, arbiter and APU decoder.
package cpu_bus_pkg;

   typedef logic [15:0] bus_addr_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_RD    = 3'd3,
      ST_WR    = 3'd4
   } dma_state_e;

   localparam bus_addr_t DMA_REG_ADDR = 16'h4014;
   localparam bus_addr_t OAMDATA_ADDR = 16'h2004;

   function automatic bus_addr_t make_addr(input logic [7:0] hi, input logic [7:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: snoops CPU writes to $4014, halts the CPU and copies page
// $XX00-$XXFF into OAMDATA as 256 read/write cycle pairs.
module oam_dma
   import cpu_bus_pkg::*;
#(
   parameter logic [15:0] DMA_REG  = DMA_REG_ADDR,
   parameter logic [15:0] OAM_DATA = OAMDATA_ADDR
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cpu_addr_h,
   input  logic [7:0] cpu_addr_l,
   input  logic       cpu_rw,
   input  logic [7:0] cpu_wdata,
   input  logic [7:0] mem_rdata,
   output logic       cpu_halt,
   output logic       dma_active,
   output logic [7:0] dma_addr_h,
   output logic [7:0] dma_addr_l,
   output logic       dma_rw,
   output logic [7:0] dma_wdata
);

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_HALT  = ST_HALT;
   localparam logic [2:0] S_ALIGN = ST_ALIGN;
   localparam logic [2:0] S_RD    = ST_RD;
   localparam logic [2:0] S_WR    = ST_WR;

   logic [2:0] state_q, state_d;
   logic       par_q, par_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] buf_q, buf_d;
   logic       trigger;

   assign trigger = !cpu_rw && (make_addr(cpu_addr_h, cpu_addr_l) == DMA_REG);

   // par free-runs so that every RD lands on an even cycle, matching the CPU's get/put phase
   always_comb begin
      state_d = state_q;
      par_d   = ~par_q;
      page_d  = page_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               page_d  = cpu_wdata;
               idx_d   = 8'd0;
               state_d = S_HALT;
            end
         end
         S_HALT:  state_d = par_q ? S_RD : S_ALIGN;
         S_ALIGN: state_d = S_RD;
         S_RD: begin
            buf_d   = mem_rdata;
            state_d = S_WR;
         end
         S_WR: begin
            idx_d   = idx_q + 8'd1;
            state_d = (idx_q == 8'hFF) ? S_IDLE : S_RD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         par_q   <= 1'b0;
         page_q  <= 8'd0;
         idx_q   <= 8'd0;
         buf_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         par_q   <= par_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
      end
   end

   // Outputs decode registered state only; nothing from cpu_* reaches dma_* combinationally
   always_comb begin
      cpu_halt   = 1'b0;
      dma_active = 1'b0;
      dma_addr_h = 8'd0;
      dma_addr_l = 8'd0;
      dma_rw     = 1'b1;
      dma_wdata  = 8'd0;
      case (state_q)
         S_HALT, S_ALIGN: cpu_halt = 1'b1;
         S_RD: begin
            cpu_halt   = 1'b1;
            dma_active = 1'b1;
            dma_addr_h = page_q;
            dma_addr_l = idx_q;
         end
         S_WR: begin
            cpu_halt   = 1'b1;
            dma_active = 1'b1;
            dma_addr_h = OAM_DATA[15:8];
            dma_addr_l = OAM_DATA[7:0];
            dma_rw     = 1'b0;
            dma_wdata  = buf_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a scoreboard of expected read addresses
// and OAMDATA write bytes.
module tb_oam_dma;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] cpu_addr_h, cpu_addr_l, cpu_wdata, mem_rdata;
   logic       cpu_rw;
   logic       cpu_halt, dma_active, dma_rw;
   logic [7:0] dma_addr_h, dma_addr_l, dma_wdata;

   int n_cmp  = 0;
   int n_fail = 0;
   bit tb_par = 1'b0;
   bit mode   = 1'b0;
   logic [15:0] exp_addr_q[$];
   logic [7:0]  exp_data_q[$];

   always #5 clk = ~clk;

   // Memory model: mode 1 returns addr_l ^ A5, mode 0 mixes in the page too
   assign mem_rdata = mode ? (dma_addr_l ^ 8'hA5) : (dma_addr_l ^ dma_addr_h ^ 8'h3C);

   oam_dma dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_addr_h (cpu_addr_h),
      .cpu_addr_l (cpu_addr_l),
      .cpu_rw     (cpu_rw),
      .cpu_wdata  (cpu_wdata),
      .mem_rdata  (mem_rdata),
      .cpu_halt   (cpu_halt),
      .dma_active (dma_active),
      .dma_addr_h (dma_addr_h),
      .dma_addr_l (dma_addr_l),
      .dma_rw     (dma_rw),
      .dma_wdata  (dma_wdata)
   );

   task automatic step();
      @(posedge clk);
      tb_par = rst_n ? ~tb_par : 1'b0;
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cpu_drive(input logic rw, input logic [15:0] addr, input logic [7:0] data);
      cpu_rw     = rw;
      cpu_addr_h = addr[15:8];
      cpu_addr_l = addr[7:0];
      cpu_wdata  = data;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_halt"},   16'(cpu_halt),   16'd0);
      chk({tag, "_active"}, 16'(dma_active), 16'd0);
      chk({tag, "_rw"},     16'(dma_rw),     16'd1);
      chk({tag, "_addr"},   {dma_addr_h, dma_addr_l}, 16'h0000);
      chk({tag, "_wdata"},  16'(dma_wdata),  16'd0);
   endtask

   // want_align: trigger in an odd-parity cycle so HALT sees par=0 and ALIGN is inserted
   task automatic run_xfer(input logic [7:0] pg, input bit want_align, input bit inject,
                           input int abort_idx);
      int  halted, aligns, writes, k;
      bit  done;
      logic [15:0] ea;
      logic [7:0]  ed;
      if (tb_par != want_align) step();
      for (int i = 0; i < 256; i++) begin
         exp_addr_q.push_back({pg, 8'(i)});
         exp_data_q.push_back(mode ? (8'(i) ^ 8'hA5) : (8'(i) ^ pg ^ 8'h3C));
      end
      cpu_drive(1'b0, 16'h4014, pg);
      step();
      cpu_drive(1'b1, 16'h0000, 8'h00);
      chk("halt_rise", 16'(cpu_halt), 16'd1);
      chk("halt_cycle_no_bus", 16'(dma_active), 16'd0);
      halted = 1; aligns = 0; writes = 0; k = 0; done = 1'b0;
      while (!done && k < 600) begin
         k++;
         if (inject && k == 20) cpu_drive(1'b0, 16'h4014, 8'h07);
         else cpu_drive(1'b1, 16'h0000, 8'h00);
         step();
         if (!cpu_halt) begin
            done = 1'b1;
            chk("active_falls_with_halt", 16'(dma_active), 16'd0);
         end else begin
            halted++;
            if (!dma_active) aligns++;
            else if (dma_rw) begin
               ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 16'hxxxx;
               chk("rd_addr", {dma_addr_h, dma_addr_l}, ea);
               if (abort_idx >= 0 && dma_addr_l == 8'(abort_idx)) begin
                  rst_n = 1'b0;
                  step();
                  rst_n = 1'b1;
                  chk_idle("abort");
                  exp_addr_q.delete();
                  exp_data_q.delete();
                  return;
               end
            end else begin
               ed = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 8'hxx;
               chk("wr_addr", {dma_addr_h, dma_addr_l}, 16'h2004);
               chk("wr_data", 16'(dma_wdata), 16'(ed));
               writes++;
            end
         end
      end
      if (!done) chk("xfer_timeout", 16'd0, 16'd1);
      chk("halted_cycles", 16'(halted), want_align ? 16'd514 : 16'd513);
      chk("align_cycles",  16'(aligns), 16'(want_align));
      chk("write_count",   16'(writes), 16'd256);
      chk("rd_left",       16'(exp_addr_q.size()), 16'd0);
      chk("wr_left",       16'(exp_data_q.size()), 16'd0);
      exp_addr_q.delete();
      exp_data_q.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_drive(1'b1, 16'h0000, 8'h00);
      step();
      step();
      chk_idle("reset");
      rst_n = 1'b1;

      cpu_drive(1'b0, 16'h4000, 8'h12);
      step();
      cpu_drive(1'b1, 16'h4014, 8'h00);
      chk("other_addr_no_halt", 16'(cpu_halt), 16'd0);
      step();
      cpu_drive(1'b1, 16'h0000, 8'h00);
      step();
      chk("read_4014_no_halt", 16'(cpu_halt), 16'd0);

      run_xfer(8'h03, 1'b0, 1'b0, -1);
      chk_idle("after_even");
      run_xfer(8'h03, 1'b1, 1'b0, -1);
      chk_idle("after_odd");

      mode = 1'b1;
      run_xfer(8'hFF, 1'b0, 1'b0, -1);
      mode = 1'b0;
      chk_idle("after_page_ff");

      run_xfer(8'h05, 1'b0, 1'b0, 'h40);
      step();
      chk_idle("post_abort_idle");
      run_xfer(8'h06, 1'b1, 1'b0, -1);

      run_xfer(8'h02, 1'b0, 1'b1, -1);
      chk_idle("after_retrigger");

      cpu_drive(1'b0, 16'h4014, 8'h09);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      cpu_drive(1'b1, 16'h0000, 8'h00);
      step();
      chk("reset_beats_trigger", 16'(cpu_halt), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite DMA engine on the 2A03 CPU memory bus, downstream of the CPU core's `mem_addr_h`/`mem_addr_l`/`mem_rw`/`mem_data` port. It snoops CPU writes to $4014 and halts the CPU. It then takes ownership of the bus and copies the 256 bytes of page `$XX00–$XXFF` into the PPU's OAMDATA register ($2004), one byte per read/write cycle pair. When the copy is done it returns the bus to the CPU.

## Interface
Parameters:
- `DMA_REG`, 16'h4014, CPU write address that triggers a transfer.
- `OAM_DATA`, 16'h2004, destination address for every DMA write.

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: reset; synchronous and active-low.
- `cpu_addr_h` in 8: CPU address high byte.
- `cpu_addr_l` in 8: CPU address low byte.
- `cpu_rw` in 1: CPU direction; 1 = read, 0 = write.
- `cpu_wdata` in 8: CPU write data.
- `mem_rdata` in 8: read data from system memory, valid in the same cycle as the address.
- `cpu_halt` out 1: stalls the CPU; the CPU holds its state while this is high.
- `dma_active` out 1: bus-owner select; 1 means the system bus takes `dma_*` instead of `cpu_*`.
- `dma_addr_h` out 8: DMA address high byte.
- `dma_addr_l` out 8: DMA address low byte.
- `dma_rw` out 1: DMA direction, same encoding as `cpu_rw`.
- `dma_wdata` out 8: DMA write data.

## Operation
- States:
  - IDLE: no transfer; bus belongs to the CPU.
  - HALT: first stall cycle after the trigger.
  - ALIGN: one extra stall cycle, used only when needed for parity.
  - RD: DMA read cycle.
  - WR: DMA write cycle.
- Trigger: in IDLE, a sampled cycle with `cpu_rw`=0 and `{cpu_addr_h,cpu_addr_l}`==`DMA_REG` does the following:
  - latches `page`<=`cpu_wdata`;
  - clears `idx`<=0;
  - moves to HALT.
- Parity bit `par`:
  - 0 after reset, then toggles every cycle regardless of state.
  - Used to decide whether ALIGN is needed.
- HALT exits to RD if `par`==1 in the HALT cycle, otherwise to ALIGN. This guarantees every RD cycle has `par`==0.
- ALIGN always exits to RD.
- RD cycle:
  - drives `dma_addr`={`page`,`idx`} with `dma_rw`=1;
  - latches `mem_rdata` into `buf` at the end of the cycle;
  - moves to WR.
- WR cycle:
  - drives `dma_addr`=`OAM_DATA`, `dma_rw`=0, `dma_wdata`=`buf`;
  - `idx`<=`idx`+1 (8-bit, wraps 255→0);
  - moves to RD, or to IDLE if `idx` was 255.
- Output decode per state:
  - `cpu_halt`=1 in HALT, ALIGN, RD and WR.
  - `dma_active`=1 in RD and WR only.
  - In IDLE, HALT and ALIGN: `dma_rw`=1 and `dma_addr`/`dma_wdata`=0.
- `page`=$FF is legal and reads $FF00–$FFFF; the address never carries into the high byte.
- Writes to `DMA_REG` while not in IDLE are ignored; `page` is unchanged.
- CPU reads of `DMA_REG` and writes to other addresses never trigger a transfer.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state = IDLE, `par`=0, `page`=0, `idx`=0, `buf`=0;
  - outputs: `cpu_halt`=0, `dma_active`=0, `dma_rw`=1, `dma_addr_h`/`dma_addr_l`/`dma_wdata`=0.
- Reset mid-transfer aborts immediately. The bus returns to the CPU in the cycle after the reset edge, and no partial state survives.
- Latency:
  - `cpu_halt` rises in the cycle after the trigger cycle.
  - The first RD comes 1 or 2 cycles after that, depending on `par`.
- Duration: 513 stall cycles (HALT + 256×2), or 514 with ALIGN.
- `cpu_halt` and `dma_active` fall together in the cycle after the final WR (`idx`=255).
- All outputs are registered-state decodes; there is no combinational path from `cpu_*` to `dma_*`.
- Trigger and reset in the same cycle: reset wins.

## Structure
- Shared package `cpu_bus_pkg` holds:
  - the state enum (IDLE, HALT, ALIGN, RD, WR);
  - constants `DMA_REG_ADDR` and `OAMDATA_ADDR`;
  - the 16-bit address helper type, for reuse by the bus arbiter and the APU register decoder.
- Single module, no sub-modules. Counter, parity bit and FSM are small enough to stay inline.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles → all outputs at reset values. CPU write of $12 to $4000 → no halt.
- Even-aligned trigger: write $03 to $4014 with HALT landing on `par`=1 → 513 halted cycles. Reads $0300..$03FF, each followed by a write of that byte to $2004 with `dma_rw`=0. `idx` wraps to 0.
- Odd-aligned trigger: same stimulus shifted one cycle → one ALIGN cycle (`dma_active`=0) and 514 halted cycles total.
- Page $FF with memory returning `addr_l` XOR $A5 → WR data sequence $A5,$A4,…,$5A. The last read address is $FFFF, with no carry into the high byte.
- Abort: `rst_n`=0 at RD with `idx`=$40 → next cycle `cpu_halt`=0 and `dma_active`=0. A fresh $4014 write restarts at `idx`=0.
- Re-trigger ignore: CPU-side write to $4014 with value $07 presented during a transfer of page $02 → `page` stays $02. Exactly 256 writes occur, then IDLE.
